// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between decode (master) and the immediate-extension unit (slave).
// Carries the input immediate/mode stream and the extended-operand output stream.
interface imm_ext_pipe_if #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int CNT_W = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [IN_W-1:0]  imm;
   logic [1:0]       mode;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] ext_result;
   logic [CNT_W-1:0] ext_count;

   modport master (
      output in_valid, imm, mode, out_ready,
      input  in_ready, out_valid, ext_result, ext_count
   );

   modport slave (
      input  in_valid, imm, mode, out_ready,
      output in_ready, out_valid, ext_result, ext_count
   );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: ZERO/SIGN/UPPER/BRANCH extension behind a
// valid/ready handshake with a main + skid register pair (2-entry FIFO).
module imm_ext_pipe #(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int SHIFT = 2,
   parameter int CNT_W = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   imm_ext_pipe_if.slave bus
);
   localparam logic [1:0] MODE_ZERO   = 2'b00;
   localparam logic [1:0] MODE_SIGN   = 2'b01;
   localparam logic [1:0] MODE_UPPER  = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;

   function automatic logic [OUT_W-1:0] ext_fn(input logic [IN_W-1:0] imm_v,
                                               input logic [1:0] mode_v);
      logic [OUT_W-1:0] zero_v;
      logic [OUT_W-1:0] sign_v;
      logic [OUT_W-1:0] res_v;
      zero_v = OUT_W'(imm_v);
      sign_v = OUT_W'($signed(imm_v));
      case (mode_v)
         MODE_ZERO:   res_v = zero_v;
         MODE_SIGN:   res_v = sign_v;
         MODE_UPPER:  res_v = zero_v << (OUT_W - IN_W);
         MODE_BRANCH: res_v = sign_v << SHIFT;
         default:     res_v = zero_v;
      endcase
      return res_v;
   endfunction

   logic             main_valid_r;
   logic [OUT_W-1:0] main_data_r;
   logic             skid_valid_r;
   logic [OUT_W-1:0] skid_data_r;
   logic             in_ready_r;
   logic [CNT_W-1:0] count_r;

   logic             in_xfer_s;
   logic             out_xfer_s;
   logic [OUT_W-1:0] f_s;
   logic             main_valid_s;
   logic [OUT_W-1:0] main_data_s;
   logic             skid_valid_s;
   logic [OUT_W-1:0] skid_data_s;
   logic [CNT_W-1:0] count_s;

   // Next-state of the main/skid pair; skid always drains into main before new input lands there
   always_comb begin
      in_xfer_s    = bus.in_valid & in_ready_r;
      out_xfer_s   = main_valid_r & bus.out_ready;
      f_s          = ext_fn(bus.imm, bus.mode);
      main_valid_s = main_valid_r;
      main_data_s  = main_data_r;
      skid_valid_s = skid_valid_r;
      skid_data_s  = skid_data_r;
      if (out_xfer_s) begin
         if (skid_valid_r) begin
            main_data_s  = skid_data_r;
            skid_valid_s = 1'b0;
         end else if (in_xfer_s) begin
            main_data_s  = f_s;
            main_valid_s = 1'b1;
         end else begin
            main_valid_s = 1'b0;
         end
      end else if (in_xfer_s) begin
         if (main_valid_r) begin
            skid_data_s  = f_s;
            skid_valid_s = 1'b1;
         end else begin
            main_data_s  = f_s;
            main_valid_s = 1'b1;
         end
      end else begin
         main_valid_s = main_valid_r;
      end
      if (out_xfer_s) begin
         count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_s = count_r;
      end
   end

   // State registers; in_ready is registered from the next skid occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {OUT_W{1'b0}};
         skid_valid_r <= 1'b0;
         skid_data_r  <= {OUT_W{1'b0}};
         in_ready_r   <= 1'b1;
         count_r      <= {CNT_W{1'b0}};
      end else begin
         main_valid_r <= main_valid_s;
         main_data_r  <= main_data_s;
         skid_valid_r <= skid_valid_s;
         skid_data_r  <= skid_data_s;
         in_ready_r   <= ~skid_valid_s;
         count_r      <= count_s;
      end
   end

   assign bus.in_ready   = in_ready_r;
   assign bus.out_valid  = main_valid_r;
   assign bus.ext_result = main_data_r;
   assign bus.ext_count  = count_r;
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: constant vector table, handshake corner sequences and a
// randomized run against a queue-based reference model.
module tb_imm_ext_pipe;
   localparam logic [1:0] M_ZERO   = 2'b00;
   localparam logic [1:0] M_SIGN   = 2'b01;
   localparam logic [1:0] M_UPPER  = 2'b10;
   localparam logic [1:0] M_BRANCH = 2'b11;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   imm_ext_pipe_if #(.IN_W(16), .OUT_W(32), .CNT_W(16)) a ();
   imm_ext_pipe_if #(.IN_W(12), .OUT_W(16), .CNT_W(4))  b ();

   imm_ext_pipe #(.IN_W(16), .OUT_W(32), .SHIFT(2), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(a));
   imm_ext_pipe #(.IN_W(12), .OUT_W(16), .SHIFT(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          inst;
      logic [1:0]  mode;
      logic [15:0] imm;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs[10];
   longint      q[$];
   longint      mcount;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference extension from arithmetic on the immediate's numeric value
   function automatic longint ref_ext(int in_w, int out_w, int sh, longint imm_v, int mode_v);
      longint mask;
      longint sv;
      mask = (longint'(1) << out_w) - 1;
      sv   = (imm_v >= (longint'(1) << (in_w - 1))) ? imm_v - (longint'(1) << in_w) : imm_v;
      case (mode_v)
         0:       return imm_v & mask;
         1:       return sv & mask;
         2:       return (imm_v * (longint'(1) << (out_w - in_w))) & mask;
         default: return (sv * (longint'(1) << sh)) & mask;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One cycle of the random run: compare against the model, then let the edge happen
   task automatic rnd_cycle();
      bit ix;
      bit ox;
      longint e;
      check("rnd_in_ready", a.in_ready, (q.size() < 2) ? 32'd1 : 32'd0);
      check("rnd_out_valid", a.out_valid, (q.size() > 0) ? 32'd1 : 32'd0);
      check("rnd_count", a.ext_count, 32'(mcount & 64'hFFFF));
      ix = a.in_valid && (q.size() < 2);
      ox = a.out_ready && (q.size() > 0);
      if (ox) begin
         e = q.pop_front();
         check("rnd_data", a.ext_result, 32'(e));
         mcount++;
      end
      if (ix) q.push_back(ref_ext(16, 32, 2, longint'(a.imm), int'(a.mode)));
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      mcount = 0;
      rst_n = 1'b0;
      a.in_valid = 1'b0; a.imm = 16'h0; a.mode = M_ZERO; a.out_ready = 1'b1;
      b.in_valid = 1'b0; b.imm = 12'h0; b.mode = M_ZERO; b.out_ready = 1'b1;

      vecs[0] = '{1'b0, M_ZERO,   16'h8001, 32'h00008001};
      vecs[1] = '{1'b0, M_SIGN,   16'h8001, 32'hFFFF8001};
      vecs[2] = '{1'b0, M_UPPER,  16'h8001, 32'h80010000};
      vecs[3] = '{1'b0, M_BRANCH, 16'h8001, 32'hFFFE0004};
      vecs[4] = '{1'b0, M_BRANCH, 16'hFFFF, 32'hFFFFFFFC};
      vecs[5] = '{1'b0, M_SIGN,   16'h7FFF, 32'h00007FFF};
      vecs[6] = '{1'b1, M_BRANCH, 16'h0800, 32'h0000F000};
      vecs[7] = '{1'b1, M_UPPER,  16'h0ABC, 32'h0000ABC0};
      vecs[8] = '{1'b1, M_SIGN,   16'h07FF, 32'h000007FF};
      vecs[9] = '{1'b1, M_SIGN,   16'h0801, 32'h0000F801};

      tick(); tick();
      check("rst_out_valid", a.out_valid, 32'd0);
      check("rst_result", a.ext_result, 32'd0);
      check("rst_count", a.ext_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_in_ready", a.in_ready, 32'd1);
      check("rst_in_ready_b", b.in_ready, 32'd1);

      for (int i = 0; i < 10; i++) begin
         a.in_valid = 1'b0;
         b.in_valid = 1'b0;
         if (vecs[i].inst) begin
            b.in_valid = 1'b1; b.imm = vecs[i].imm[11:0]; b.mode = vecs[i].mode;
         end else begin
            a.in_valid = 1'b1; a.imm = vecs[i].imm; a.mode = vecs[i].mode;
         end
         tick();
         if (vecs[i].inst) begin
            check($sformatf("vec%0d_valid", i), b.out_valid, 32'd1);
            check($sformatf("vec%0d_result", i), b.ext_result, vecs[i].exp);
         end else begin
            check($sformatf("vec%0d_valid", i), a.out_valid, 32'd1);
            check($sformatf("vec%0d_result", i), a.ext_result, vecs[i].exp);
         end
      end
      a.in_valid = 1'b0;
      b.in_valid = 1'b0;
      tick();
      check("table_count_a", a.ext_count, 32'd6);
      check("table_count_b", b.ext_count, 32'd4);
      check("table_idle_valid", a.out_valid, 32'd0);
      check("hold_result", a.ext_result, 32'h00007FFF);

      for (int i = 0; i < 13; i++) begin
         b.in_valid = 1'b1; b.imm = 12'(i); b.mode = M_ZERO;
         tick();
      end
      b.in_valid = 1'b0;
      tick();
      check("wrap_count_b", b.ext_count, 32'd1);

      a.out_ready = 1'b0;
      a.in_valid = 1'b1; a.mode = M_SIGN; a.imm = 16'h0001;
      tick();
      check("bp_first_out", a.ext_result, 32'h00000001);
      check("bp_ready1", a.in_ready, 32'd1);
      a.imm = 16'h0002;
      tick();
      check("bp_ready_low", a.in_ready, 32'd0);
      a.imm = 16'h0003;
      tick();
      check("bp_hold_ready", a.in_ready, 32'd0);
      check("bp_hold_result", a.ext_result, 32'h00000001);
      a.out_ready = 1'b1;
      tick();
      check("bp_second_out", a.ext_result, 32'h00000002);
      check("bp_ready_back", a.in_ready, 32'd1);
      tick();
      check("bp_third_out", a.ext_result, 32'h00000003);
      check("bp_third_valid", a.out_valid, 32'd1);
      a.in_valid = 1'b0;
      tick();
      check("bp_drained", a.out_valid, 32'd0);
      check("bp_count", a.ext_count, 32'd9);

      a.out_ready = 1'b0;
      a.in_valid = 1'b1; a.mode = M_ZERO; a.imm = 16'h1111;
      tick();
      a.imm = 16'h2222;
      tick();
      a.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", a.out_valid, 32'd0);
      check("arst_result", a.ext_result, 32'd0);
      check("arst_count", a.ext_count, 32'd0);
      check("arst_count_b", b.ext_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst_in_ready", a.in_ready, 32'd1);
      a.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("arst_no_stale", a.out_valid, 32'd0);
         tick();
      end

      for (int i = 0; i < 400; i++) begin
         a.in_valid  = 1'($urandom_range(0, 1));
         a.imm       = 16'($urandom);
         a.mode      = 2'($urandom_range(0, 3));
         a.out_ready = ($urandom_range(0, 3) != 0);
         rnd_cycle();
      end
      a.in_valid  = 1'b0;
      a.out_ready = 1'b1;
      for (int k = 0; k < 10 && q.size() > 0; k++) rnd_cycle();
      check("drain_empty", 32'(q.size()), 32'd0);
      check("final_count", a.ext_count, 32'(mcount & 64'hFFFF));
      check("final_valid", a.out_valid, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
- Parametrised, pipelined immediate-extension unit. Successor to the datapath's combinational 16→32 extender.
- Takes an IN_W-bit instruction immediate plus a mode select.
- Produces an OUT_W-bit operand: zero-extend, sign-extend, upper-load or branch-offset.
- Sits between decode and the ALU-operand mux behind a valid/ready handshake, with a 2-entry skid buffer so back-pressure never drops or reorders operands.

Parameters:
- IN_W, 16: immediate input width; legal range 1..OUT_W.
- OUT_W, 32: extended result width; must be ≥ IN_W.
- SHIFT, 2: left shift applied in BRANCH mode; legal range 0..OUT_W-1.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: imm/mode are valid this cycle.
- in_ready, output, 1: unit can accept; equals NOT skid_valid, driven from a register only.
- imm, input, IN_W: raw immediate field.
- mode, input, 2: 00 ZERO, 01 SIGN, 10 UPPER, 11 BRANCH.
- out_valid, output, 1: ext_result is valid.
- out_ready, input, 1: consumer accepts ext_result this cycle.
- ext_result, output, OUT_W: extended operand.
- ext_count, output, CNT_W: number of completed output transfers.

Behaviour:
- Reset (rst_n low, async): main_valid=0, skid_valid=0, out_valid=0, ext_result=0, ext_count=0, in_ready=1 (after reset releases). All stored data is discarded, including operands in flight mid-stream. No output transfer is counted.
- Extension function f(imm, mode), purely combinational on the input side:
  - ZERO: {(OUT_W-IN_W) zeros, imm}.
  - SIGN: {(OUT_W-IN_W) copies of imm[IN_W-1], imm}.
  - UPPER: {imm, (OUT_W-IN_W) zeros}. If OUT_W==IN_W, UPPER equals imm unchanged.
  - BRANCH: SIGN result shifted left by SHIFT. Low SHIFT bits are zero. Truncated to OUT_W; bits shifted out are lost.
- Input transfer: in_valid && in_ready on a rising edge.
- Output transfer: out_valid && out_ready on a rising edge.
- Storage: main register (drives ext_result/out_valid) and skid register.
- Per-cycle update:
  - Output transfer with skid_valid=1: main ← skid. If an input transfer also occurs (only possible with skid_valid=0, so excluded here).
  - Output transfer with skid_valid=0: main ← f(new input) if an input transfer occurs, else main_valid ← 0.
  - No output transfer, main_valid=0, input transfer: main ← f(input).
  - No output transfer, main_valid=1, input transfer: skid ← f(input), skid_valid ← 1.
- Latency: 1 cycle from input transfer to out_valid when the pipe is empty. Sustained throughput is 1 per cycle while out_ready=1.
- in_ready deasserts the cycle after the skid register fills. It reasserts the cycle after the skid drains into main.
- Ordering: strict FIFO, with capacity of 2 entries.
- ext_result holds its last value while out_valid=0. It changes only on a main-register load.
- Inputs are ignored when in_ready=0 or in_valid=0. mode is sampled only at the input transfer.
- ext_count increments by 1 on each output transfer. It wraps from 2^CNT_W-1 to 0.
- Simultaneous input and output transfer with one entry held: occupancy stays 1 and the new value lands in main next cycle.

Test Plan:
- Defaults, out_ready=1: send imm=0x8001 in modes ZERO, SIGN, UPPER, BRANCH on consecutive cycles → ext_result 0x00008001, 0xFFFF8001, 0x80010000, 0xFFFE0004 on 4 consecutive cycles, each 1 cycle after its input; ext_count=4.
- BRANCH imm=0xFFFF → 0xFFFFFFFC. SIGN imm=0x7FFF → 0x00007FFF.
- Back-pressure, out_ready=0, 3 back-to-back SIGN inputs 0x0001, 0x0002, 0x0003:
  - First two accepted; in_ready=0 from the cycle after the second.
  - Third is held with in_valid=1.
  - Raise out_ready → outputs 0x00000001, 0x00000002, 0x00000003 in order, no gaps; in_ready returns to 1.
- Assert rst_n=0 asynchronously (off clock edge) with both entries full → out_valid, ext_result and ext_count go to 0 immediately. in_ready=1 after release. The old operands never appear.
- Counter wrap: CNT_W=4, 17 transfers → ext_count=1.
- Parameter variant IN_W=12, OUT_W=16, SHIFT=1: BRANCH imm=0x800 → 0xF000; UPPER imm=0xABC → 0xABC0.
